// File: rtl/cond_logic_pkg.sv
// cond_pkg: shared types and constants for the conditional-execution stage.
// Holds the ARM condition-code enum, the NZCV bit positions inside the flags
// word and the decoder flagW bit meanings.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        CS = 4'h2,
        CC = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE,
        NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_logic_if.sv
// cond_logic_if: decoder-side bundle into the conditional-execution stage and
// the gated strobes / status coming back out. The decoder side is the master,
// cond_logic is the slave. CNT_W must match the cond_logic instance.
interface cond_logic_if #(parameter int CNT_W = 16);

    logic             instrValid;
    logic             stall;
    logic [3:0]       cond;
    logic [3:0]       aluFlags;
    logic [1:0]       flagW;
    logic             pcs;
    logic             regW;
    logic             memW;

    logic             pcSrc;
    logic             regWrite;
    logic             memWrite;
    logic             condEx;
    logic [3:0]       flags;
    logic             illegal;
    logic [CNT_W-1:0] squashCnt;

    modport master (
        output instrValid, stall, cond, aluFlags, flagW, pcs, regW, memW,
        input  pcSrc, regWrite, memWrite, condEx, flags, illegal, squashCnt
    );

    modport slave (
        input  instrValid, stall, cond, aluFlags, flagW, pcs, regW, memW,
        output pcSrc, regWrite, memWrite, condEx, flags, illegal, squashCnt
    );

endinterface

// File: rtl/cond_logic_cond_check.sv
// cond_check: purely combinational evaluation of a 4-bit ARM cond field
// against an NZCV flags word. Code 4'hF is never a pass; it raises illegal.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass,
    output logic       illegal
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition field into pass / illegal from the current flags
    always_comb begin
        pass    = 1'b0;
        illegal = 1'b0;
        case (cond_e'(cond))
            EQ: pass = z;
            NE: pass = ~z;
            CS: pass = c;
            CC: pass = ~c;
            MI: pass = n;
            PL: pass = ~n;
            VS: pass = v;
            VC: pass = ~v;
            HI: pass = c & ~z;
            LS: pass = ~c | z;
            GE: pass = (n == v);
            LT: pass = (n != v);
            GT: pass = ~z & (n == v);
            LE: pass = z | (n != v);
            AL: pass = 1'b1;
            NV: illegal = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// cond_logic: ARMv4 conditional-execution stage sitting behind the decoders.
// Holds the NZCV flags register, evaluates the instruction cond field against
// the registered flags (no same-cycle bypass) and squashes the decoder's
// pcs/regW/memW strobes when the condition fails.
// Optional feature: define COND_STATS_EN to build the saturating squash
// counter; otherwise squashCnt is tied to zero.
module cond_logic
    import cond_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);

    logic       go;
    logic       pass;
    logic       chkIllegal;
    logic       condEx;
    logic [3:0] flagsQ;

    assign go = bus.instrValid & ~bus.stall;

    cond_check uCheck (
        .cond    (bus.cond),
        .flags   (flagsQ),
        .pass    (pass),
        .illegal (chkIllegal)
    );

    assign condEx       = go & pass;
    assign bus.condEx   = condEx;
    assign bus.illegal  = go & chkIllegal;
    assign bus.pcSrc    = bus.pcs  & condEx;
    assign bus.regWrite = bus.regW & condEx;
    assign bus.memWrite = bus.memW & condEx;
    assign bus.flags    = flagsQ;

    // Flags register: NZ and CV fields are written independently, only by a passing instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            flagsQ <= 4'b0000;
        end else begin
            if (condEx & bus.flagW[FW_NZ]) begin
                flagsQ[FLAG_N] <= bus.aluFlags[FLAG_N];
                flagsQ[FLAG_Z] <= bus.aluFlags[FLAG_Z];
            end
            if (condEx & bus.flagW[FW_CV]) begin
                flagsQ[FLAG_C] <= bus.aluFlags[FLAG_C];
                flagsQ[FLAG_V] <= bus.aluFlags[FLAG_V];
            end
        end
    end

`ifdef COND_STATS_EN
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] squashQ;

    // Saturating count of valid, unstalled instructions that failed a legal condition
    always_ff @(posedge clk) begin
        if (reset) begin
            squashQ <= '0;
        end else if (go & ~pass & ~chkIllegal & (squashQ != '1)) begin
            squashQ <= squashQ + CntOne;
        end
    end

    assign bus.squashCnt = squashQ;
`else
    logic [CNT_W-1:0] squashZero;

    assign squashZero    = '0;
    assign bus.squashCnt = squashZero;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: scoreboard bench for cond_logic. A stimulus process drives the
// decoder bundle, predicts every output from an abstract NZCV model and pushes
// the prediction into a queue; a monitor pops one prediction per cycle and
// compares it with the DUT on the falling edge.
// Honours COND_STATS_EN for the squash counter prediction.
module tb_cond_logic;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        bit         chkStrobes;
        bit         pcSrc;
        bit         regWrite;
        bit         memWrite;
        bit         condEx;
        bit         illegal;
        logic [3:0] flags;
        int         cnt;
    } expect_t;

    logic clk = 1'b0;
    logic reset;

    expect_t sbQ[$];

    bit mN, mZ, mC, mV;
    int mCnt;
    int vectors     = 0;
    int miscompares = 0;

    cond_logic_if #(.CNT_W(CNT_W)) bus ();

    cond_logic #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ARM conditions come in complementary pairs: even code = base test, odd = its inverse
    function automatic bit condHolds(input logic [3:0] c, input bit fn, input bit fz,
                                     input bit fc, input bit fv);
        bit base;
        case (c[3:1])
            3'd0:    base = fz;
            3'd1:    base = fc;
            3'd2:    base = fn;
            3'd3:    base = fv;
            3'd4:    base = fc && !fz;
            3'd5:    base = (fn == fv);
            3'd6:    base = !fz && (fn == fv);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic compareField(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        if (e.chkStrobes) begin
            compareField("pcSrc",    16'(bus.pcSrc),    16'(e.pcSrc));
            compareField("regWrite", 16'(bus.regWrite), 16'(e.regWrite));
            compareField("memWrite", 16'(bus.memWrite), 16'(e.memWrite));
            compareField("condEx",   16'(bus.condEx),   16'(e.condEx));
            compareField("illegal",  16'(bus.illegal),  16'(e.illegal));
        end
        compareField("flags",     16'(bus.flags),     16'(e.flags));
        compareField("squashCnt", 16'(bus.squashCnt), 16'(e.cnt));
    endtask

    task automatic applyStimulus(input bit rst, input bit valid, input bit stl,
                                 input logic [3:0] c, input logic [3:0] alu,
                                 input logic [1:0] fw, input bit p, input bit rw, input bit mw);
        expect_t e;
        bit go;
        bit passed;
        @(posedge clk);
        #1;
        reset          = rst;
        bus.instrValid = valid;
        bus.stall      = stl;
        bus.cond       = c;
        bus.aluFlags   = alu;
        bus.flagW      = fw;
        bus.pcs        = p;
        bus.regW       = rw;
        bus.memW       = mw;

        go     = valid && !stl;
        passed = go && (c != 4'hF) && condHolds(c, mN, mZ, mC, mV);

        e.chkStrobes = !rst;
        e.pcSrc      = p && passed;
        e.regWrite   = rw && passed;
        e.memWrite   = mw && passed;
        e.condEx     = passed;
        e.illegal    = go && (c == 4'hF);
        e.flags      = {mN, mZ, mC, mV};
`ifdef COND_STATS_EN
        e.cnt        = mCnt;
`else
        e.cnt        = 0;
`endif
        sbQ.push_back(e);

        if (rst) begin
            {mN, mZ, mC, mV} = 4'b0000;
            mCnt = 0;
        end else begin
            if (passed && fw[1]) begin
                mN = alu[3];
                mZ = alu[2];
            end
            if (passed && fw[0]) begin
                mC = alu[1];
                mV = alu[0];
            end
            if (go && !passed && (c != 4'hF) && (mCnt < CNT_MAX))
                mCnt++;
        end
    endtask

    // Monitor: one prediction per cycle, compared away from the active edge
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        bus.instrValid = 1'b1;
        bus.stall      = 1'b0;
        bus.cond       = 4'hE;
        bus.aluFlags   = 4'hF;
        bus.flagW      = 2'b11;
        bus.pcs        = 1'b0;
        bus.regW       = 1'b0;
        bus.memW       = 1'b0;
        {mN, mZ, mC, mV} = 4'b0000;
        mCnt = 0;
        repeat (2) @(posedge clk);

        // Reset held with an AL flag write pending: flags stay clear
        applyStimulus(1, 1, 0, 4'hE, 4'hF, 2'b11, 1, 1, 1);
        // Set Z, then EQ passes and NE fails
        applyStimulus(0, 1, 0, 4'hE, 4'b0100, 2'b11, 0, 0, 0);
        applyStimulus(0, 1, 0, 4'h0, 4'hF, 2'b00, 0, 1, 0);
        applyStimulus(0, 1, 0, 4'h1, 4'hF, 2'b11, 0, 1, 0);
        // Partial CV write keeps NZ
        applyStimulus(0, 1, 0, 4'hE, 4'b1011, 2'b01, 0, 0, 0);
        // Observe 0111 while setting N=1, V=0
        applyStimulus(0, 1, 0, 4'hE, 4'b1000, 2'b11, 0, 0, 0);
        // Signed compare: LT passes, GE fails
        applyStimulus(0, 1, 0, 4'hB, 4'h0, 2'b00, 1, 0, 0);
        applyStimulus(0, 1, 0, 4'hA, 4'hF, 2'b11, 1, 0, 1);
        // Stall and bubble squash everything and hold flags
        applyStimulus(0, 1, 1, 4'hE, 4'hF, 2'b11, 1, 1, 1);
        applyStimulus(0, 0, 0, 4'hE, 4'hF, 2'b11, 1, 1, 1);
        // Illegal code
        applyStimulus(0, 1, 0, 4'hF, 4'hF, 2'b11, 1, 1, 1);
        // Z=1 then a run of failing NE to drive the counter into saturation
        applyStimulus(0, 1, 0, 4'hE, 4'b0100, 2'b10, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1, 0, 4'h1, 4'hF, 2'b11, 1, 1, 1);
        // Mid-operation reset clears flags and counter
        applyStimulus(1, 1, 0, 4'hE, 4'hF, 2'b11, 0, 0, 0);
        applyStimulus(0, 1, 0, 4'h9, 4'h0, 2'b00, 0, 1, 0);

        // Randomized traffic with occasional stalls, bubbles and resets
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 31) == 0,
                          $urandom_range(0, 5) != 0,
                          $urandom_range(0, 5) == 0,
                          4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 10 && sbQ.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sbQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", sbQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
